pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

- Stall/flush controller for the five-stage pipeline (pc, if, id, ex, mem, wb).
- Collects hold requests from the id, ex and mem stages and redirect requests from exception/branch logic.
- Drives one per-stage stall vector and one flush strobe, which gate the pipeline registers around the id decoder and its forwarding paths.
- Owns the multi-cycle ex wait, including a watchdog that force-releases a hung ex unit.

## Interface
Parameters:
- `EX_TIMEOUT`, default 32: maximum number of consecutive ex-stall cycles before forced release. Legal range 2..255.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `id_stall_req`  in  1  — load-use interlock from id. Ex holds a load whose destination matches an id source register.
- `ex_stall_req`  in  1  — ex holds a multi-cycle operation.
- `ex_done`  in  1  — ex multi-cycle result is valid this cycle.
- `mem_stall_req`  in  1  — data memory not ready.
- `flush_req`  in  1  — redirect; kill the younger stages.
- `stall`  out  6  — per-stage hold. Bit mapping: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb.
- `flush`  out  1  — clear the if/id, id/ex and ex/mem registers this cycle.
- `ex_timeout`  out  1  — one-cycle pulse on watchdog release.
- `ctrl_state`  out  2  — current FSM state: 0 = RUN, 1 = EX_WAIT.
- `stall_cycles`  out  32  — count of cycles with `stall[0]`=1; see Configuration.

## Operation
- FSM states: RUN, EX_WAIT. An 8-bit `ex_cnt` counter runs alongside the FSM.
- `stall` and `flush` are combinational from state, `ex_cnt` and the request inputs.
- Request priority, highest first: flush_req > mem_stall_req > ex hold > id_stall_req.

Stall and flush values:
- `flush_req`=1: `flush`=1, `stall`=6'b000000. The FSM goes to RUN with `ex_cnt`=0, which aborts any ex wait.
- `mem_stall_req`=1 (no flush): `stall`=6'b011111.
- Ex hold active (no flush, no mem): `stall`=6'b001111.
- `id_stall_req` only: `stall`=6'b000111, a single bubble. No state change.
- No request: `stall`=0, `flush`=0.

Ex hold:
- Ex hold is active in either of two cases:
  - RUN with `ex_stall_req`=1 and `ex_done`=0.
  - EX_WAIT with `ex_done`=0 and `ex_cnt` < `EX_TIMEOUT`.
- RUN → EX_WAIT when `ex_stall_req`=1 and `ex_done`=0, with no flush. Set `ex_cnt`=1.
  - This happens even while mem is stalling, because ex is busy regardless.
- RUN with `ex_stall_req`=1 and `ex_done`=1: single-cycle completion. No ex stall, stay in RUN.
- EX_WAIT with `ex_done`=1: ex hold releases that cycle; → RUN, `ex_cnt`=0.
- EX_WAIT with `ex_done`=0 and `ex_cnt` < `EX_TIMEOUT`: `ex_cnt` increments.
- EX_WAIT with `ex_cnt`==`EX_TIMEOUT` and `ex_done`=0: `ex_timeout`=1, ex hold releases; → RUN, `ex_cnt`=0.
- `ex_done` and timeout in the same cycle: `ex_done` wins, `ex_timeout`=0.
- `ex_stall_req` is ignored while in EX_WAIT; only `ex_done`, timeout or flush exit the state.

## Timing
Reset:
- `rst`=1 immediately forces state=RUN, `ex_cnt`=0, `stall_cycles`=0.
- While `rst`=1, outputs are forced: `stall`=0, `flush`=0, `ex_timeout`=0, `ctrl_state`=0.
- Reset in the middle of an EX_WAIT discards the wait; no timeout pulse is generated.

Latency:
- Request to `stall`/`flush`: zero cycles (combinational).
- State and counter updates: one cycle.

Ex wait cycle counts:
- Ex request at cycle 0 with `ex_done` asserted at cycle k (1 ≤ k < `EX_TIMEOUT`): ex stall is high on cycles 0..k-1 and low at cycle k.
- Hung ex unit: ex stall is high on exactly `EX_TIMEOUT` cycles; `ex_timeout` pulses on cycle `EX_TIMEOUT`.

Other boundary behaviour:
- A flush in the same cycle as `ex_done` or timeout: `flush`=1, `ex_timeout`=0.
- `mem_stall_req` during EX_WAIT: `stall`=6'b011111, and `ex_cnt` keeps counting.

## Configuration
- Macro: `PIPE_CTRL_STALL_CNT_EN`.
- Defined:
  - `stall_cycles` is a 32-bit register that increments on every clock where `stall[0]`=1.
  - It saturates at 32'hFFFFFFFF.
  - It is cleared only by `rst`.
- Undefined: `stall_cycles` is tied to 32'h0 and no counter logic is built. The port is kept in both cases.

## Test plan
- Reset: assert `rst` mid-EX_WAIT (`ex_cnt`=5) → same cycle `stall`=0, `ctrl_state`=0. After release, `ex_stall_req`=0 → `stall` stays 0.
- Load-use: `id_stall_req`=1 for one cycle → `stall`=6'b000111 for exactly that cycle, `ctrl_state` stays 0.
- Multi-cycle ex:
  - Stimulus: `ex_stall_req` at cycle 0, `ex_done` at cycle 4.
  - Response: `stall`=6'b001111 on cycles 0–3, 0 on cycle 4, `ctrl_state`=1 on cycles 1–4.
  - With the macro defined, `stall_cycles`=4.
- Watchdog: `EX_TIMEOUT`=8, `ex_stall_req` pulse, `ex_done` never asserted → 8 stall cycles, `ex_timeout`=1 on cycle 8 only, back to RUN.
- Priority:
  - Stimulus: in EX_WAIT, `mem_stall_req`=1 → `stall`=6'b011111.
  - Then `flush_req`=1 together with `mem_stall_req`=1.
  - Response: `flush`=1, `stall`=0, next `ctrl_state`=0, no `ex_timeout` pulse.
- Same-cycle done: in RUN, `ex_stall_req`=1 and `ex_done`=1 → `stall`=0, `ctrl_state` stays 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with ex multi-cycle wait and watchdog; optional stall counter under PIPE_CTRL_STALL_CNT_EN.
// stall/flush/ex_timeout are combinational from state and requests; state updates one cycle later; no backpressure of its own.
module pipe_ctrl #(
  parameter int unsigned EX_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall_req,
  input  logic        ex_stall_req,
  input  logic        ex_done,
  input  logic        mem_stall_req,
  input  logic        flush_req,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        ex_timeout,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_WAIT = 2'd1
  } state_e;

  localparam logic [7:0] TMO = 8'(EX_TIMEOUT);

  state_e     state_q;
  logic [7:0] ex_cnt_q;

  logic ex_start;
  logic wait_hold;
  logic wdog_fire;
  logic ex_hold;

  assign ex_start  = (state_q == RUN) && ex_stall_req && !ex_done;
  assign wait_hold = (state_q == EX_WAIT) && !ex_done && (ex_cnt_q < TMO);
  assign wdog_fire = (state_q == EX_WAIT) && !ex_done && (ex_cnt_q >= TMO);
  assign ex_hold   = ex_start || wait_hold;

  // Flush outranks every hold; reset forces all strobes low.
  always_comb begin
    stall = 6'b000000;
    if (!rst && !flush_req) begin
      if (mem_stall_req)     stall = 6'b011111;
      else if (ex_hold)      stall = 6'b001111;
      else if (id_stall_req) stall = 6'b000111;
    end
  end

  assign flush      = !rst && flush_req;
  assign ex_timeout = !rst && !flush_req && wdog_fire;
  assign ctrl_state = state_q;

  // The ex wait keeps counting under a mem stall: the ex unit is busy either way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      ex_cnt_q <= 8'd0;
    end else if (flush_req) begin
      state_q  <= RUN;
      ex_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_start) begin
            state_q  <= EX_WAIT;
            ex_cnt_q <= 8'd1;
          end
        end
        EX_WAIT: begin
          if (wait_hold) begin
            ex_cnt_q <= ex_cnt_q + 8'd1;
          end else begin
            state_q  <= RUN;
            ex_cnt_q <= 8'd0;
          end
        end
        default: begin
          state_q  <= RUN;
          ex_cnt_q <= 8'd0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  assign stall_cycles_d = (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) ?
                          stall_cycles_q + 32'd1 : stall_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles_q <= 32'd0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus randomized traffic against a behavioural model.
module tb_pipe_ctrl;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stall_req = 1'b0;
  logic        ex_stall_req = 1'b0;
  logic        ex_done = 1'b0;
  logic        mem_stall_req = 1'b0;
  logic        flush_req = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_timeout;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.EX_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .id_stall_req(id_stall_req), .ex_stall_req(ex_stall_req), .ex_done(ex_done),
    .mem_stall_req(mem_stall_req), .flush_req(flush_req),
    .stall(stall), .flush(flush), .ex_timeout(ex_timeout),
    .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: an ex job is "busy" from the cycle after its request; it has a
  // budget of T hold cycles in total (the request cycle spends one of them).
  bit      m_busy = 1'b0;
  int      m_spent = 0;
  longint  m_stalls = 0;

  logic       e_hold, e_tmo;
  logic [5:0] e_stall;
  always @* begin
    e_hold = 1'b0;
    e_tmo  = 1'b0;
    if (!m_busy) e_hold = ex_stall_req && !ex_done;
    else if (!ex_done) begin
      if (m_spent < T) e_hold = 1'b1;
      else             e_tmo  = 1'b1;
    end
    if (rst || flush_req)  e_stall = 6'b000000;
    else if (mem_stall_req) e_stall = 6'b011111;
    else if (e_hold)        e_stall = 6'b001111;
    else if (id_stall_req)  e_stall = 6'b000111;
    else                    e_stall = 6'b000000;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   = 1'b0;
      m_spent  = 0;
      m_stalls = 0;
    end else begin
      if (e_stall[0] && m_stalls < 64'hFFFF_FFFF) m_stalls = m_stalls + 1;
      if (flush_req) m_busy = 1'b0;
      else if (!m_busy) begin
        if (ex_stall_req && !ex_done) begin
          m_busy  = 1'b1;
          m_spent = 1;
        end
      end else if (ex_done || m_spent >= T) m_busy = 1'b0;
      else m_spent = m_spent + 1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e_sc;
`ifdef PIPE_CTRL_STALL_CNT_EN
    e_sc = m_stalls[31:0];
`else
    e_sc = 32'h0;
`endif
    chk("model_stall", {26'd0, stall}, {26'd0, e_stall});
    chk("model_flush", {31'd0, flush}, {31'd0, (!rst && flush_req)});
    chk("model_tmo", {31'd0, ex_timeout}, {31'd0, (!rst && !flush_req && e_tmo)});
    chk("model_state", {30'd0, ctrl_state}, {30'd0, (rst ? 1'b0 : m_busy)});
    chk("model_stall_cycles", stall_cycles, e_sc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic ex, input logic dn,
                       input logic mem, input logic fl);
    id_stall_req  = id;
    ex_stall_req  = ex;
    ex_done       = dn;
    mem_stall_req = mem;
    flush_req     = fl;
  endtask

  initial begin
    #2;
    chk("rst_stall", {26'd0, stall}, 32'd0);
    chk("rst_state", {30'd0, ctrl_state}, 32'd0);
    chk("rst_sc", stall_cycles, 32'd0);
    step(); step();
    rst = 1'b0;

    // Load-use bubble for exactly one cycle
    step(); drive(1, 0, 0, 0, 0); #2;
    chk("lu_stall", {26'd0, stall}, 32'h07);
    chk("lu_state", {30'd0, ctrl_state}, 32'd0);
    step(); drive(0, 0, 0, 0, 0); #2;
    chk("lu_after", {26'd0, stall}, 32'd0);

    // Multi-cycle ex: request at cycle 0, done at cycle 4
    for (int c = 0; c <= 5; c++) begin
      step();
      drive(0, c == 0, c == 4, 0, 0);
      #2;
      chk("mc_stall", {26'd0, stall}, (c < 4) ? 32'h0F : 32'h0);
      chk("mc_state", {30'd0, ctrl_state}, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
    end

    // Watchdog: done never comes
    for (int c = 0; c <= 9; c++) begin
      step();
      drive(0, c == 0, 0, 0, 0);
      #2;
      chk("wd_stall", {26'd0, stall}, (c < T) ? 32'h0F : 32'h0);
      chk("wd_tmo", {31'd0, ex_timeout}, (c == T) ? 32'd1 : 32'd0);
      if (c == 9) chk("wd_state", {30'd0, ctrl_state}, 32'd0);
    end

    // Priority: mem over ex wait, then flush over everything
    step(); drive(0, 1, 0, 0, 0);
    step(); drive(0, 0, 0, 1, 0); #2;
    chk("pr_mem", {26'd0, stall}, 32'h1F);
    step(); drive(0, 0, 0, 1, 1); #2;
    chk("pr_flush", {31'd0, flush}, 32'd1);
    chk("pr_fl_stall", {26'd0, stall}, 32'd0);
    chk("pr_fl_tmo", {31'd0, ex_timeout}, 32'd0);
    step(); drive(0, 0, 0, 0, 0); #2;
    chk("pr_state", {30'd0, ctrl_state}, 32'd0);

    // Single-cycle completion
    step(); drive(0, 1, 1, 0, 0); #2;
    chk("sc_stall", {26'd0, stall}, 32'd0);
    step(); drive(0, 0, 0, 0, 0); #2;
    chk("sc_state", {30'd0, ctrl_state}, 32'd0);

    // Flush on the timeout cycle suppresses the pulse
    for (int c = 0; c <= T; c++) begin
      step();
      drive(0, c == 0, 0, 0, c == T);
    end
    #2;
    chk("ft_flush", {31'd0, flush}, 32'd1);
    chk("ft_tmo", {31'd0, ex_timeout}, 32'd0);

    // Reset in the middle of a wait (ex_cnt = 5)
    for (int c = 0; c <= 5; c++) begin
      step();
      drive(0, c == 0, 0, 0, 0);
    end
    #1;
    chk("rm_pre_state", {30'd0, ctrl_state}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_stall", {26'd0, stall}, 32'd0);
    chk("rm_state", {30'd0, ctrl_state}, 32'd0);
    step(); step();
    rst = 1'b0;
    #2;
    chk("rm_after", {26'd0, stall}, 32'd0);
    step(); #2;
    chk("rm_no_tmo", {31'd0, ex_timeout}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0);
    end
    step();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
